cnt7_run_ctrl: RTL and testbench

Run controller for the mod-7 count datapath: accepts a start command with a run length, steps the 3-bit mod-7 counter through exactly that many counts, supports hold and abort, and signals completion. Sits between the command/sequencing logic and the counter, so no other block drives the counter's enable or clear directly.

---
 rtl/cnt7_run_ctrl_pkg.sv | 19 +
 rtl/cnt7_run_ctrl_cnt.sv | 29 ++
 rtl/cnt7_run_ctrl.sv | 111 +++++++++++
 tb/tb_cnt7_run_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cnt7_run_ctrl_pkg.sv
// Shared types and constants for the mod-7 run controller and its counter.
package cnt7_run_ctrl_pkg;

    localparam int unsigned CNT_W     = 3;
    localparam int unsigned MOD       = 7;
    localparam int unsigned DEF_LEN_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Successor of a count; anything at or above MOD-1 (including the illegal 7) returns to 0.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] q);
        return (q >= CNT_W'(MOD - 1)) ? '0 : q + CNT_W'(1);
    endfunction

endpackage

// File: rtl/cnt7_run_ctrl_cnt.sv
// Mod-7 counter with enable, synchronous clear and a load-7 test hook.
module mod7_cnt
    import cnt7_run_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             ld7,
    output logic [CNT_W-1:0] q,
    output logic             tc_c
);

    logic [CNT_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_q <= '0;
        end else if (ld7) begin
            r_q <= CNT_W'(7);
        end else if (en) begin
            r_q <= cnt_next(r_q);
        end
    end

    assign q    = r_q;
    assign tc_c = (r_q == CNT_W'(MOD - 1));

endmodule

// File: rtl/cnt7_run_ctrl.sv
// Run controller: accepts start/len, steps the mod-7 counter len times, handles hold and clr.
module cnt7_run_ctrl
    import cnt7_run_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             hold,
    input  logic             clr,
    input  logic             tst_force7,
    output logic             ack,
    output logic             busy,
    output logic             wrap,
    output logic             done,
    output logic [CNT_W-1:0] CNT
);

    state_t           r_state;
    state_t           w_nxt;
    logic [LEN_W-1:0] r_rem;
    logic             r_ack;
    logic             r_busy;
    logic             r_wrap;
    logic             r_done;
    logic             w_adv;
    logic             w_accept;
    logic             w_tc;
    logic [CNT_W-1:0] w_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    // Next state plus the advance/accept strobes; clr pre-empts everything.
    always_comb begin
        w_nxt    = r_state;
        w_adv    = 1'b0;
        w_accept = 1'b0;
        if (clr) begin
            w_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && (len != '0)) begin
                        w_nxt    = ST_RUN;
                        w_accept = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!hold) begin
                        w_adv = 1'b1;
                        if (r_rem == LEN_W'(1)) begin
                            w_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: w_nxt = ST_IDLE;
                default: w_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_rem <= '0;
        end else if (w_accept) begin
            r_rem <= len;
        end else if (w_adv) begin
            r_rem <= r_rem - LEN_W'(1);
        end
    end

    // Output pulses are registered from the same-cycle decisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack  <= 1'b0;
            r_busy <= 1'b0;
            r_wrap <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_ack  <= w_accept;
            r_busy <= (w_nxt != ST_IDLE);
            r_wrap <= w_adv && w_tc;
            r_done <= (w_nxt == ST_DONE);
        end
    end

    mod7_cnt u_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (w_adv),
        .clr  (clr),
        .ld7  (tst_force7),
        .q    (w_q),
        .tc_c (w_tc)
    );

    assign ack  = r_ack;
    assign busy = r_busy;
    assign wrap = r_wrap;
    assign done = r_done;
    assign CNT  = w_q;

endmodule

// File: tb/tb_cnt7_run_ctrl.sv
// Directed bench for cnt7_run_ctrl with hand-computed per-cycle expectations.
module tb_cnt7_run_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       hold;
    logic       clr;
    logic       tst_force7;
    logic       ack;
    logic       busy;
    logic       wrap;
    logic       done;
    logic [2:0] CNT;

    int n_chk;
    int n_err;

    cnt7_run_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .hold       (hold),
        .clr        (clr),
        .tst_force7 (tst_force7),
        .ack        (ack),
        .busy       (busy),
        .wrap       (wrap),
        .done       (done),
        .CNT        (CNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input int a, input int b,
                           input int w, input int d);
        chk({tag, ".cnt"},  CNT,               3'(c));
        chk({tag, ".ack"},  {2'b00, ack},      3'(a));
        chk({tag, ".busy"}, {2'b00, busy},     3'(b));
        chk({tag, ".wrap"}, {2'b00, wrap},     3'(w));
        chk({tag, ".done"}, {2'b00, done},     3'(d));
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1; start = 1'b0; len = 4'd0; hold = 1'b0; clr = 1'b0; tst_force7 = 1'b0;
        step(); step();
        chk_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        chk_all("idle0", 0, 0, 0, 0, 0);

        // len=5 from 0
        start = 1'b1; len = 4'd5;
        step(); chk_all("r1.acc", 0, 1, 1, 0, 0);
        start = 1'b0;
        step(); chk_all("r1.c1", 1, 0, 1, 0, 0);
        step(); chk_all("r1.c2", 2, 0, 1, 0, 0);
        step(); chk_all("r1.c3", 3, 0, 1, 0, 0);
        step(); chk_all("r1.c4", 4, 0, 1, 0, 0);
        step(); chk_all("r1.c5", 5, 0, 1, 0, 1);
        step(); chk_all("r1.end", 5, 0, 0, 0, 0);

        // len=4 from 5, crosses the wrap
        start = 1'b1; len = 4'd4;
        step(); chk_all("r2.acc", 5, 1, 1, 0, 0);
        start = 1'b0;
        step(); chk_all("r2.c6", 6, 0, 1, 0, 0);
        step(); chk_all("r2.c0", 0, 0, 1, 1, 0);
        step(); chk_all("r2.c1", 1, 0, 1, 0, 0);
        step(); chk_all("r2.c2", 2, 0, 1, 0, 1);
        step(); chk_all("r2.end", 2, 0, 0, 0, 0);

        // clr in IDLE, then len=3 with two held cycles
        clr = 1'b1;
        step(); chk_all("clr.idle", 0, 0, 0, 0, 0);
        clr = 1'b0; start = 1'b1; len = 4'd3;
        step(); chk_all("r3.acc", 0, 1, 1, 0, 0);
        start = 1'b0;
        step(); chk_all("r3.c1", 1, 0, 1, 0, 0);
        hold = 1'b1;
        step(); chk_all("r3.h1", 1, 0, 1, 0, 0);
        step(); chk_all("r3.h2", 1, 0, 1, 0, 0);
        hold = 1'b0;
        step(); chk_all("r3.c2", 2, 0, 1, 0, 0);
        step(); chk_all("r3.c3", 3, 0, 1, 0, 1);
        step(); chk_all("r3.end", 3, 0, 0, 0, 0);

        // len=0 start is ignored
        start = 1'b1; len = 4'd0;
        step(); chk_all("len0.a", 3, 0, 0, 0, 0);
        step(); chk_all("len0.b", 3, 0, 0, 0, 0);

        // len=9, start re-asserted mid-run, then clr+start at CNT=3
        len = 4'd9;
        step(); chk_all("r4.acc", 3, 1, 1, 0, 0);
        start = 1'b0;
        step(); chk_all("r4.c4", 4, 0, 1, 0, 0);
        start = 1'b1; len = 4'd2;
        step(); chk_all("r4.c5", 5, 0, 1, 0, 0);
        step(); chk_all("r4.c6", 6, 0, 1, 0, 0);
        start = 1'b0;
        step(); chk_all("r4.c0", 0, 0, 1, 1, 0);
        step(); chk_all("r4.c1", 1, 0, 1, 0, 0);
        step(); chk_all("r4.c2", 2, 0, 1, 0, 0);
        step(); chk_all("r4.c3", 3, 0, 1, 0, 0);
        clr = 1'b1; start = 1'b1; len = 4'd5;
        step(); chk_all("r4.clr", 0, 0, 0, 0, 0);
        clr = 1'b0;
        step(); chk_all("r5.acc", 0, 1, 1, 0, 0);
        start = 1'b0;
        step(); chk_all("r5.c1", 1, 0, 1, 0, 0);
        step(); chk_all("r5.c2", 2, 0, 1, 0, 0);

        // rst mid-run
        rst = 1'b1;
        step(); chk_all("rst.mid", 0, 0, 0, 0, 0);
        rst = 1'b0;
        step(); chk_all("rst.idle", 0, 0, 0, 0, 0);

        // illegal CNT=7 recovers on the next advance, without a wrap pulse
        tst_force7 = 1'b1;
        step(); chk_all("f7.load", 7, 0, 0, 0, 0);
        tst_force7 = 1'b0; start = 1'b1; len = 4'd1;
        step(); chk_all("f7.acc", 7, 1, 1, 0, 0);
        start = 1'b0;
        step(); chk_all("f7.adv", 0, 0, 1, 0, 1);
        step(); chk_all("f7.end", 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
